// File: rtl/uart_rx_drain_ctrl.sv
// uart_rx_drain_ctrl: pops bytes from the UART receiver FIFO in bursts and forwards them,
// with their parity/framing flags, on a valid/ready stream. A burst starts when the FIFO
// hits its threshold or when a non-empty FIFO has sat idle for TIMEOUT_CYC cycles.
// Also keeps saturating error counters, a sticky overrun flag and a level interrupt.
//
// Build option: define ERR_DROP_EN to discard bytes carrying pe|fre instead of forwarding
// them (they are still popped, counted and charged against the burst limit).
module uart_rx_drain_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned BURST_MAX   = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_en,
  input  logic             rx_thr,
  input  logic             rx_empty,
  input  logic             rx_busy,
  input  logic [7:0]       rx_data,
  input  logic             rx_pe,
  input  logic             rx_fre,
  input  logic             rx_ov,
  output logic             rd_en,
  output logic [7:0]       m_data,
  output logic [1:0]       m_err,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             irq,
  input  logic             irq_clr,
  output logic [2:0]       cause,
  output logic [CNT_W-1:0] pe_cnt,
  output logic [CNT_W-1:0] fre_cnt,
  output logic             ov_seen
);

  localparam int unsigned TmoW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned BurstW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {StIdle, StPop, StCapt, StSend} state_e;

  state_e state_q, state_d;

  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [BurstW-1:0] burst_q, burst_d, burst_inc;
  logic [7:0]        m_data_q, m_data_d;
  logic [1:0]        m_err_q, m_err_d;
  logic [CNT_W-1:0]  pe_cnt_q, pe_cnt_d;
  logic [CNT_W-1:0]  fre_cnt_q, fre_cnt_d;
  logic [2:0]        cause_q, cause_d, cause_set;
  logic              ov_seen_q, ov_seen_d;
  logic              irq_q;

  logic tmo_hit, start, more, capt, err_byte, drop, hs;

  assign tmo_hit   = (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1));
  assign start     = ctrl_en & ~rx_empty & (rx_thr | tmo_hit);
  assign capt      = (state_q == StCapt);
  assign hs        = (state_q == StSend) & m_ready;
  assign err_byte  = rx_pe | rx_fre;
  assign burst_inc = burst_q + BurstW'(1);
  // Decided on the byte just finished (handshaken or dropped), so compare the incremented count
  assign more      = ctrl_en & ~rx_empty & (burst_inc < BurstW'(BURST_MAX));

`ifdef ERR_DROP_EN
  assign drop = err_byte;
`else
  assign drop = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StPop;
      // Only reachable with a non-empty FIFO; the empty guard is defensive
      StPop:  state_d = rx_empty ? StIdle : StCapt;
      StCapt: begin
        if (drop) state_d = more ? StPop : StIdle;
        else      state_d = StSend;
      end
      StSend: if (m_ready) state_d = more ? StPop : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: pop strobe and stream valid
  always_comb begin
    rd_en   = (state_q == StPop) & ~rx_empty;
    m_valid = (state_q == StSend);
  end

  // Timeout counter next state: runs only while idle with a quiet, non-empty FIFO
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if ((state_q != StIdle) || rx_empty || rx_busy) tmo_cnt_d = '0;
    else if (!tmo_hit)                              tmo_cnt_d = tmo_cnt_q + TmoW'(1);
  end

  // Burst counter next state
  always_comb begin
    burst_d = burst_q;
    if ((state_q == StIdle) && start) burst_d = '0;
    else if (hs || (capt && drop))    burst_d = burst_inc;
  end

  // Capture path and saturating error counters
  always_comb begin
    m_data_d  = m_data_q;
    m_err_d   = m_err_q;
    pe_cnt_d  = pe_cnt_q;
    fre_cnt_d = fre_cnt_q;
    if (capt) begin
      m_data_d = rx_data;
`ifdef ERR_DROP_EN
      m_err_d  = 2'b00;
`else
      m_err_d  = {rx_pe, rx_fre};
`endif
      if (rx_pe && (pe_cnt_q != {CNT_W{1'b1}}))   pe_cnt_d  = pe_cnt_q + CNT_W'(1);
      if (rx_fre && (fre_cnt_q != {CNT_W{1'b1}})) fre_cnt_d = fre_cnt_q + CNT_W'(1);
    end
  end

  // Interrupt causes and overrun flag; a set in the same cycle as irq_clr wins
  always_comb begin
    cause_set[0] = (state_q == StIdle) & start & rx_thr;
    cause_set[1] = (state_q == StIdle) & start & ~rx_thr;
    cause_set[2] = capt & err_byte;
    cause_d      = (cause_q & ~{3{irq_clr}}) | cause_set;
    ov_seen_d    = (ov_seen_q & ~irq_clr) | rx_ov;
  end

  // Datapath and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      burst_q   <= '0;
      m_data_q  <= '0;
      m_err_q   <= '0;
      pe_cnt_q  <= '0;
      fre_cnt_q <= '0;
      cause_q   <= '0;
      ov_seen_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      burst_q   <= burst_d;
      m_data_q  <= m_data_d;
      m_err_q   <= m_err_d;
      pe_cnt_q  <= pe_cnt_d;
      fre_cnt_q <= fre_cnt_d;
      cause_q   <= cause_d;
      ov_seen_q <= ov_seen_d;
      irq_q     <= (|cause_q) | ov_seen_q;
    end
  end

  assign m_data  = m_data_q;
  assign m_err   = m_err_q;
  assign cause   = cause_q;
  assign irq     = irq_q;
  assign pe_cnt  = pe_cnt_q;
  assign fre_cnt = fre_cnt_q;
  assign ov_seen = ov_seen_q;

endmodule

// File: tb/tb_uart_rx_drain_ctrl.sv
// Directed bench for uart_rx_drain_ctrl with a small FIFO model on the receiver side.
module tb_uart_rx_drain_ctrl;

  localparam int unsigned TimeoutCyc = 16;
  localparam int unsigned BurstMax   = 16;
  localparam int unsigned CntW       = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            ctrl_en, rx_thr, rx_empty, rx_busy, rx_ov;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_pe = 1'b0;
  logic            rx_fre = 1'b0;
  logic            rd_en;
  logic [7:0]      m_data;
  logic [1:0]      m_err;
  logic            m_valid, m_ready;
  logic            irq, irq_clr;
  logic [2:0]      cause;
  logic [CntW-1:0] pe_cnt, fre_cnt;
  logic            ov_seen;

  always #5 clk = ~clk;

  uart_rx_drain_ctrl #(
    .TIMEOUT_CYC(TimeoutCyc),
    .BURST_MAX  (BurstMax),
    .CNT_W      (CntW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ctrl_en (ctrl_en),
    .rx_thr  (rx_thr),
    .rx_empty(rx_empty),
    .rx_busy (rx_busy),
    .rx_data (rx_data),
    .rx_pe   (rx_pe),
    .rx_fre  (rx_fre),
    .rx_ov   (rx_ov),
    .rd_en   (rd_en),
    .m_data  (m_data),
    .m_err   (m_err),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .irq     (irq),
    .irq_clr (irq_clr),
    .cause   (cause),
    .pe_cnt  (pe_cnt),
    .fre_cnt (fre_cnt),
    .ov_seen (ov_seen)
  );

  // Receiver FIFO model: bench writes at wr_ptr, pops advance rd_ptr, data 1 cycle after rd_en
  logic [7:0] fifo_data [0:255];
  logic       fifo_pe   [0:255];
  logic       fifo_fre  [0:255];
  int         wr_ptr  = 0;
  int         rd_ptr  = 0;
  int         rd_cnt  = 0;
  int         rd_viol = 0;
  int         hs_cnt  = 0;
  logic [7:0] hs_data [0:255];
  logic [1:0] hs_err  [0:255];

  assign rx_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (wr_ptr == rd_ptr) begin
        rd_viol <= rd_viol + 1;
      end else begin
        rx_data <= fifo_data[rd_ptr];
        rx_pe   <= fifo_pe[rd_ptr];
        rx_fre  <= fifo_fre[rd_ptr];
        rd_ptr  <= rd_ptr + 1;
      end
    end
    if (m_valid && m_ready) begin
      hs_data[hs_cnt] <= m_data;
      hs_err[hs_cnt]  <= m_err;
      hs_cnt          <= hs_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fre);
    fifo_data[wr_ptr] = d;
    fifo_pe[wr_ptr]   = pe;
    fifo_fre[wr_ptr]  = fre;
    wr_ptr++;
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int n = 0;
    while (!m_valid && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, m_valid, 1'b1);
  endtask

  task automatic pulse_clr();
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
  endtask

  initial begin
    int base_hs, base_rd, first, bad;
    logic [1:0] err_or;

    reset = 1'b1; ctrl_en = 1'b0; rx_thr = 1'b0; rx_busy = 1'b0; rx_ov = 1'b0;
    m_ready = 1'b1; irq_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_cause", cause, 3'b000);
    check("rst_pe_cnt", pe_cnt, 0);
    check("rst_fre_cnt", fre_cnt, 0);
    check("rst_ov_seen", ov_seen, 1'b0);
    check("rst_m_data", m_data, 8'h00);
    check("rst_m_err", m_err, 2'b00);
    reset = 1'b0; ctrl_en = 1'b1;
    @(negedge clk);

    // Threshold burst of four clean bytes
    base_hs = hs_cnt; base_rd = rd_cnt;
    push(8'h11, 0, 0); push(8'h22, 0, 0); push(8'h33, 0, 0); push(8'h44, 0, 0);
    rx_thr = 1'b1;
    @(negedge clk);
    check("thr_rd_first", rd_en, 1'b1);
    check("thr_cause", cause, 3'b001);
    check("thr_irq_lag", irq, 1'b0);
    @(negedge clk);
    check("thr_irq", irq, 1'b1);
    check("thr_rd_single", rd_en, 1'b0);
    rx_thr = 1'b0;
    repeat (16) @(negedge clk);
    check("thr_hs_count", hs_cnt - base_hs, 4);
    check("thr_rd_count", rd_cnt - base_rd, 4);
    err_or = 2'b00;
    for (int i = 0; i < 4; i++) begin
      check("thr_data", hs_data[base_hs + i], 8'h11 * (i + 1));
      err_or = err_or | hs_err[base_hs + i];
    end
    check("thr_err", err_or, 2'b00);
    check("thr_idle", m_valid, 1'b0);
    pulse_clr();
    check("clr_cause", cause, 3'b000);
    @(negedge clk);
    check("clr_irq", irq, 1'b0);

    // Timeout drain of a single byte
    base_hs = hs_cnt;
    push(8'h5A, 0, 0);
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rd_en && first == 0) first = k;
    end
    check("tmo_latency", first, 16);
    check("tmo_cause", cause, 3'b010);
    check("tmo_data", hs_data[base_hs], 8'h5A);
    pulse_clr();

    // Timeout restarted by a busy pulse sampled on the 10th edge
    base_hs = hs_cnt;
    push(8'hC3, 0, 0);
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rd_en && first == 0) first = k;
      if (k == 9)  rx_busy = 1'b1;
      if (k == 10) rx_busy = 1'b0;
    end
    check("tmo_busy_latency", first, 26);
    check("tmo_busy_cause", cause, 3'b010);
    check("tmo_busy_data", hs_data[base_hs], 8'hC3);
    pulse_clr();

    // Parity-error byte with downstream stalled
    base_hs = hs_cnt;
    m_ready = 1'b0;
    rx_thr = 1'b1;
    push(8'hA5, 1, 0);
`ifdef ERR_DROP_EN
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_valid) bad++;
    end
    rx_thr = 1'b0;
    check("pe_drop_no_valid", bad, 0);
`else
    wait_valid("pe_valid", 10);
    rx_thr = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!(m_valid === 1'b1 && m_data === 8'hA5 && m_err === 2'b10)) bad++;
    end
    check("pe_hold_stable", bad, 0);
`endif
    check("pe_cnt", pe_cnt, 1);
    check("pe_cause", cause[2], 1'b1);
    m_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Framing-error byte
    rx_thr = 1'b1;
    push(8'h0F, 0, 1);
`ifdef ERR_DROP_EN
    repeat (10) @(negedge clk);
    rx_thr = 1'b0;
    check("fre_drop_no_hs", hs_cnt - base_hs, 0);
`else
    wait_valid("fre_valid", 10);
    rx_thr = 1'b0;
    check("fre_data", m_data, 8'h0F);
    check("fre_err", m_err, 2'b01);
    repeat (3) @(negedge clk);
`endif
    check("fre_cnt", fre_cnt, 1);
    pulse_clr();

    // Burst limit: 20 bytes, busy held so the timeout cannot retrigger
    base_hs = hs_cnt; base_rd = rd_cnt;
    rx_busy = 1'b1;
    for (int i = 0; i < 20; i++) push(8'h80 + 8'(i), 0, 0);
    rx_thr = 1'b1;
    @(negedge clk);
    rx_thr = 1'b0;
    repeat (60) @(negedge clk);
    check("burst_hs_first", hs_cnt - base_hs, 16);
    check("burst_rd_first", rd_cnt - base_rd, 16);
    check("burst_idle_valid", m_valid, 1'b0);
    check("burst_idle_rd", rd_en, 1'b0);
    check("burst_last", hs_data[base_hs + 15], 8'h8F);
    rx_thr = 1'b1;
    @(negedge clk);
    rx_thr = 1'b0;
    repeat (20) @(negedge clk);
    check("burst_hs_total", hs_cnt - base_hs, 20);
    check("burst2_first", hs_data[base_hs + 16], 8'h90);
    check("burst2_last", hs_data[base_hs + 19], 8'h93);
    rx_busy = 1'b0;

    // Overrun flag versus irq_clr
    pulse_clr();
    @(negedge clk);
    check("ov_irq_quiet", irq, 1'b0);
    rx_ov = 1'b1;
    @(negedge clk);
    rx_ov = 1'b0;
    check("ov_set", ov_seen, 1'b1);
    @(negedge clk);
    check("ov_irq", irq, 1'b1);
    rx_ov = 1'b1; irq_clr = 1'b1;
    @(negedge clk);
    rx_ov = 1'b0; irq_clr = 1'b0;
    check("ov_set_wins", ov_seen, 1'b1);
    @(negedge clk);
    check("ov_irq_held", irq, 1'b1);
    pulse_clr();
    check("ov_cleared", ov_seen, 1'b0);
    @(negedge clk);
    check("ov_irq_cleared", irq, 1'b0);

    // Reset while a byte waits in SEND
    m_ready = 1'b0;
    rx_thr = 1'b1;
    push(8'h3C, 0, 0);
    wait_valid("rst_send_valid", 10);
    reset = 1'b1;
    @(negedge clk);
    check("rst_send_m_valid", m_valid, 1'b0);
    check("rst_send_rd_en", rd_en, 1'b0);
    check("rst_send_pe_cnt", pe_cnt, 0);
    check("rst_send_fre_cnt", fre_cnt, 0);
    check("rst_send_cause", cause, 3'b000);
    check("rst_send_irq", irq, 1'b0);
    check("rst_send_m_data", m_data, 8'h00);
    reset = 1'b0; rx_thr = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    check("rd_while_empty", rd_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_drain_ctrl.md
Name: uart_rx_drain_ctrl

Overview:
Controller that sequences the UART receiver FIFO. It decides when to pop bytes and issues single-cycle read strobes. It forwards each byte with its error flags onto a valid/ready stream toward the bus/DMA side, and raises an interrupt on threshold, timeout or error. It sits between uart_receiver and the register/interrupt logic.

Parameters:
TIMEOUT_CYC, 1024, idle cycles (receiver not busy, FIFO non-empty) before a timeout drain starts
BURST_MAX, 16, max bytes popped per drain burst before returning to IDLE
CNT_W, 8, width of the saturating error counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ctrl_en  in  1  controller enable; 0 = no new bursts
rx_thr  in  1  receiver FIFO threshold reached
rx_empty  in  1  receiver FIFO empty
rx_busy  in  1  receiver frame in progress (rx_bclk_en)
rx_data  in  8  receiver data_out, valid 1 cycle after rd_en
rx_pe  in  1  parity error of popped byte
rx_fre  in  1  framing error of popped byte
rx_ov  in  1  receiver overrun level
rd_en  out  1  single-cycle pop strobe to receiver read_en
m_data  out  8  output byte
m_err  out  2  {pe, fre} of output byte
m_valid  out  1  output valid
m_ready  in  1  downstream ready
irq  out  1  interrupt (level)
irq_clr  in  1  clear pending interrupt causes
cause  out  3  pending causes {err, timeout, thr}
pe_cnt  out  CNT_W  saturating parity-error count
fre_cnt  out  CNT_W  saturating framing-error count
ov_seen  out  1  sticky overrun flag

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0.
- Reset is synchronous and active-high. Reset mid-burst aborts immediately: no further rd_en, and m_valid drops on the next edge.
- FSM states: IDLE, POP, CAPT, SEND.
- IDLE -> POP when ctrl_en & ~rx_empty & (rx_thr | tmo_hit). On entry, set the cause bit thr or timeout (thr wins if both) and clear the burst counter.
- POP: rd_en=1 for exactly one cycle, then go to CAPT. rd_en is never asserted while rx_empty=1.
- CAPT: register rx_data, rx_pe, rx_fre into m_data/m_err; go to SEND. This covers the 1-cycle read latency. The pop-to-m_valid latency is 2 clocks.
- SEND: m_valid=1. m_data and m_err are held stable until m_valid & m_ready.
- On the handshake, increment the burst counter. Go to POP if ~rx_empty & ctrl_en & burst<BURST_MAX; otherwise go to IDLE.
- In SEND, m_valid deasserts on the cycle after the handshake unless the next byte is already captured. No bubble-free requirement: minimum 3 cycles per byte.
- ctrl_en dropping mid-burst: the current byte completes its handshake, then the FSM returns to IDLE.
- Timeout counter: counts while FSM=IDLE & ~rx_empty & ~rx_busy. It clears when rx_busy=1, when rx_empty=1, or when the FSM leaves IDLE.
- tmo_hit is asserted when count == TIMEOUT_CYC-1. The counter saturates there and does not wrap.
- Error counters: incremented when a byte with the corresponding flag is captured in CAPT. They saturate at 2^CNT_W-1 and clear only on reset.
- Any captured error sets cause[2].
- ov_seen is set on any cycle with rx_ov=1. It is cleared by irq_clr, but not in a cycle where rx_ov=1 (set wins).
- irq = |cause | ov_seen, registered (1-cycle latency from the cause being set).
- irq_clr clears cause bits. If a cause sets in the same cycle as irq_clr, set wins.

Optional Feature:
ERR_DROP_EN:
- Defined: bytes with pe|fre are popped and counted, then discarded. CAPT goes directly to the POP/IDLE decision without SEND, and the discarded byte counts toward BURST_MAX. m_err is tied to 0.
- Undefined: all bytes are forwarded with m_err flags.

Test Plan:
- rx_thr=1 with 4 bytes 0x11,0x22,0x33,0x44 in FIFO, m_ready=1 -> 4 rd_en pulses, m_data sequence 0x11..0x44 with m_err=0, cause=3'b001, irq=1 one cycle after cause sets.
- 1 byte 0x5A, rx_thr=0, rx_busy=0, TIMEOUT_CYC=16 -> rd_en exactly 16 cycles after FIFO becomes non-empty, cause=3'b010; repeating with a rx_busy pulse at cycle 10 restarts the count.
- Byte 0xA5 with rx_pe=1, m_ready held 0 for 20 cycles -> m_valid and m_data=0xA5, m_err=2'b10 stable for all 20 cycles, pe_cnt=1, cause[2]=1. With ERR_DROP_EN: no m_valid, pe_cnt=1.
- 20 bytes in FIFO, BURST_MAX=16 -> 16 handshakes, return to IDLE, second burst of 4 after re-trigger.
- rx_ov pulse and irq_clr in the same cycle -> ov_seen=1, irq stays 1; irq_clr alone later -> irq=0.
- reset=1 asserted in SEND -> next edge m_valid=0, rd_en=0, all counters 0.
